// File: rtl/even_stat_acc.sv
// even_stat_acc: windowed even/odd sample statistics with valid/ready result handoff (optional EVEN_CHECK_EN self-check)
module even_stat_acc #(
    parameter int NUM_SIZE = 12,
    parameter int WINDOW = 16,
    localparam int CNT_W = $clog2(WINDOW + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_SIZE-1:0] num,
    input  logic                is_even,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CNT_W-1:0]    even_cnt,
    output logic [CNT_W-1:0]    odd_cnt,
    output logic [NUM_SIZE-1:0] last_even
`ifdef EVEN_CHECK_EN
    ,
    output logic                chk_err
`endif
);
    typedef enum logic {ACCUM, REPORT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_t state;
    logic [CNT_W-1:0] smp_cnt;
    logic acc;
    assign acc = in_valid && in_ready;
    // window accumulation and result handoff; handshake outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            even_cnt  <= '0;
            odd_cnt   <= '0;
            last_even <= '0;
            smp_cnt   <= '0;
        end else if (state == ACCUM) begin
            if (acc) begin
                if (is_even) begin
                    even_cnt  <= even_cnt + ONE;
                    last_even <= num;
                end else begin
                    odd_cnt <= odd_cnt + ONE;
                end
                smp_cnt <= smp_cnt + ONE;
                if (smp_cnt == LAST) begin
                    state     <= REPORT;
                    in_ready  <= 1'b0;
                    res_valid <= 1'b1;
                end
            end
        end else if (res_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            even_cnt  <= '0;
            odd_cnt   <= '0;
            last_even <= '0;
            smp_cnt   <= '0;
        end
    end
`ifdef EVEN_CHECK_EN
    // sticky flag when the upstream parity flag disagrees with the number's LSB
    always_ff @(posedge clk) begin
        if (rst) chk_err <= 1'b0;
        else if (acc && (is_even != ~num[0])) chk_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_even_stat_acc.sv
// tb_even_stat_acc: randomized and directed checks of even_stat_acc against a queue-based window model
module tb_even_stat_acc;
    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int errors = 0;
    always #5 clk = ~clk;

    logic a_in_valid, a_in_ready, a_is_even, a_res_valid, a_res_ready;
    logic [11:0] a_num, a_last;
    logic [2:0] a_even, a_odd;
    logic b_in_valid, b_in_ready, b_is_even, b_res_valid, b_res_ready;
    logic [11:0] b_num, b_last;
    logic [4:0] b_even, b_odd;
    logic c_in_valid, c_in_ready, c_is_even, c_res_valid, c_res_ready;
    logic [11:0] c_num, c_last;
    logic [0:0] c_even, c_odd;
`ifdef EVEN_CHECK_EN
    logic a_chk, b_chk, c_chk;
`endif

    even_stat_acc #(.NUM_SIZE(12), .WINDOW(4)) d4 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .num(a_num),
        .is_even(a_is_even), .res_valid(a_res_valid), .res_ready(a_res_ready),
        .even_cnt(a_even), .odd_cnt(a_odd), .last_even(a_last)
`ifdef EVEN_CHECK_EN
        , .chk_err(a_chk)
`endif
    );
    even_stat_acc d16 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .num(b_num),
        .is_even(b_is_even), .res_valid(b_res_valid), .res_ready(b_res_ready),
        .even_cnt(b_even), .odd_cnt(b_odd), .last_even(b_last)
`ifdef EVEN_CHECK_EN
        , .chk_err(b_chk)
`endif
    );
    even_stat_acc #(.NUM_SIZE(12), .WINDOW(1)) d1 (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .num(c_num),
        .is_even(c_is_even), .res_valid(c_res_valid), .res_ready(c_res_ready),
        .even_cnt(c_even), .odd_cnt(c_odd), .last_even(c_last)
`ifdef EVEN_CHECK_EN
        , .chk_err(c_chk)
`endif
    );

    task automatic do_reset();
        rst = 1'b1;
        {a_in_valid, a_res_ready, a_is_even} = '0; a_num = '0;
        {b_in_valid, b_res_ready, b_is_even} = '0; b_num = '0;
        {c_in_valid, c_res_ready, c_is_even} = '0; c_num = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({a_in_ready, a_res_valid, a_even, a_odd, a_last} !== {1'b1, 1'b0, 3'd0, 3'd0, 12'd0}) begin
            errors++;
            $display("FAIL reset_w4 got rdy=%b vld=%b e=%0d o=%0d le=%0d exp rdy=1 vld=0 e=0 o=0 le=0",
                     a_in_ready, a_res_valid, a_even, a_odd, a_last);
        end
        tests++;
        if ({b_in_ready, b_res_valid, b_even, b_odd, b_last} !== {1'b1, 1'b0, 5'd0, 5'd0, 12'd0}) begin
            errors++;
            $display("FAIL reset_w16 got rdy=%b vld=%b e=%0d o=%0d le=%0d exp rdy=1 vld=0 e=0 o=0 le=0",
                     b_in_ready, b_res_valid, b_even, b_odd, b_last);
        end
`ifdef EVEN_CHECK_EN
        tests++;
        if (a_chk !== 1'b0) begin errors++; $display("FAIL reset_chk got %b exp 0", a_chk); end
`endif
    endtask

    // feeds four correctly flagged samples back to back, holds the result for `hold` cycles,
    // then releases it with junk on the input in the handoff cycle
    task automatic feed4(input logic [11:0] n0, n1, n2, n3, input int hold, input string tag);
        logic [11:0] v[4];
        logic [2:0] ev, od;
        logic [11:0] le;
        v = '{n0, n1, n2, n3};
        ev = 0; od = 0; le = 0;
        foreach (v[i]) if (v[i] % 2 == 0) begin ev++; le = v[i]; end else od++;
        a_res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_num = v[i]; a_is_even = (v[i] % 2 == 0);
            tests++;
            if ({a_in_ready, a_res_valid} !== 2'b10) begin
                errors++;
                $display("FAIL %s accept%0d got rdy=%b vld=%b exp rdy=1 vld=0", tag, i, a_in_ready, a_res_valid);
            end
            @(negedge clk);
        end
        for (int h = 0; h <= hold; h++) begin
            tests++;
            if ({a_res_valid, a_in_ready, a_even, a_odd, a_last} !== {1'b1, 1'b0, ev, od, le}) begin
                errors++;
                $display("FAIL %s result[%0d] got vld=%b rdy=%b e=%0d o=%0d le=%0d exp vld=1 rdy=0 e=%0d o=%0d le=%0d",
                         tag, h, a_res_valid, a_in_ready, a_even, a_odd, a_last, ev, od, le);
            end
            a_in_valid = 1'b1; a_num = 12'($urandom); a_is_even = ~a_num[0];
            a_res_ready = (h == hold);
            @(negedge clk);
        end
        a_in_valid = 1'b0; a_res_ready = 1'b0;
        tests++;
        if ({a_res_valid, a_in_ready, a_even, a_odd, a_last} !== {1'b0, 1'b1, 3'd0, 3'd0, 12'd0}) begin
            errors++;
            $display("FAIL %s release got vld=%b rdy=%b e=%0d o=%0d le=%0d exp vld=0 rdy=1 e=0 o=0 le=0",
                     tag, a_res_valid, a_in_ready, a_even, a_odd, a_last);
        end
    endtask

    task automatic test_basic();
        do_reset();
        feed4(12'd2, 12'd7, 12'd10, 12'd3, 0, "basic");
    endtask

    task automatic test_all_odd();
        feed4(12'd1, 12'd3, 12'd5, 12'd7, 0, "all_odd");
    endtask

    task automatic test_backpressure();
        feed4(12'd100, 12'd33, 12'd35, 12'd37, 5, "bp_hold");
        feed4(12'd9, 12'd4, 12'd11, 12'd13, 0, "bp_fresh");
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 3; w++) begin
            feed4(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 0, "b2b");
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_in_valid = 1'b1; a_num = 12'd4; a_is_even = 1'b1;
        @(negedge clk);
        a_num = 12'd8;
        @(negedge clk);
        a_in_valid = 1'b0;
        tests++;
        if ({a_even, a_odd, a_last} !== {3'd2, 3'd0, 12'd8}) begin
            errors++;
            $display("FAIL mid_window got e=%0d o=%0d le=%0d exp e=2 o=0 le=8", a_even, a_odd, a_last);
        end
        do_reset();
        tests++;
        if ({a_in_ready, a_res_valid, a_even, a_odd, a_last} !== {1'b1, 1'b0, 3'd0, 3'd0, 12'd0}) begin
            errors++;
            $display("FAIL rst_mid got rdy=%b vld=%b e=%0d o=%0d le=%0d exp rdy=1 vld=0 e=0 o=0 le=0",
                     a_in_ready, a_res_valid, a_even, a_odd, a_last);
        end
        feed4(12'd6, 12'd8, 12'd9, 12'd11, 0, "after_rst");
    endtask

    task automatic test_window1();
        logic [11:0] n;
        for (int i = 0; i < 6; i++) begin
            n = 12'($urandom);
            c_in_valid = 1'b1; c_num = n; c_is_even = (n % 2 == 0); c_res_ready = 1'b0;
            @(negedge clk);
            c_in_valid = 1'b1; c_num = 12'($urandom); c_is_even = ~c_num[0]; c_res_ready = 1'b1;
            tests++;
            if ({c_res_valid, c_in_ready, c_even, c_odd, c_last} !==
                {1'b1, 1'b0, n % 2 == 0, n % 2 != 0, (n % 2 == 0) ? n : 12'd0}) begin
                errors++;
                $display("FAIL w1_result n=%0d got vld=%b rdy=%b e=%0d o=%0d le=%0d", n,
                         c_res_valid, c_in_ready, c_even, c_odd, c_last);
            end
            @(negedge clk);
            c_in_valid = 1'b0; c_res_ready = 1'b0;
            tests++;
            if ({c_res_valid, c_in_ready, c_even, c_odd} !== 4'b0100) begin
                errors++;
                $display("FAIL w1_release got vld=%b rdy=%b e=%0d o=%0d exp vld=0 rdy=1 e=0 o=0",
                         c_res_valid, c_in_ready, c_even, c_odd);
            end
        end
    endtask

    task automatic test_gapped();
        logic [11:0] q[$];
        logic [4:0] ev, od;
        logic [11:0] le;
        logic rdy, rv, exp_rv;
        int acc = 0;
        int cyc = 0;
        do_reset();
        while (acc < 50 && cyc < 3000) begin
            rdy = b_in_ready; rv = b_res_valid;
            b_in_valid = ($urandom_range(0, 2) != 0);
            b_num = 12'($urandom); b_is_even = (b_num % 2 == 0);
            b_res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (b_in_valid && rdy) begin q.push_back(b_num); acc++; end
            if (rv && b_res_ready) q.delete();
            ev = 0; od = 0; le = 0;
            foreach (q[i]) if (q[i] % 2 == 0) begin ev++; le = q[i]; end else od++;
            exp_rv = (q.size() == 16);
            tests++;
            if ({b_res_valid, b_in_ready, b_even, b_odd, b_last} !== {exp_rv, !exp_rv, ev, od, le}) begin
                errors++;
                $display("FAIL gapped cyc=%0d got vld=%b rdy=%b e=%0d o=%0d le=%0d exp vld=%b rdy=%b e=%0d o=%0d le=%0d",
                         cyc, b_res_valid, b_in_ready, b_even, b_odd, b_last, exp_rv, !exp_rv, ev, od, le);
            end
            if (b_res_valid === 1'b1) begin
                tests++;
                if (b_even + b_odd !== 5'd16) begin
                    errors++;
                    $display("FAIL gapped_sum got %0d exp 16", b_even + b_odd);
                end
            end
        end
        b_in_valid = 1'b0; b_res_ready = 1'b0;
        tests++;
        if (acc < 50) begin
            errors++;
            $display("FAIL gapped_timeout accepted %0d exp 50", acc);
        end
`ifdef EVEN_CHECK_EN
        tests++;
        if (b_chk !== 1'b0) begin errors++; $display("FAIL gapped_chk got %b exp 0", b_chk); end
`endif
    endtask

`ifdef EVEN_CHECK_EN
    task automatic test_chk();
        do_reset();
        a_in_valid = 1'b1; a_num = 12'd5; a_is_even = 1'b1;
        @(negedge clk);
        a_num = 12'd6; a_is_even = 1'b1;
        tests++;
        if ({a_chk, a_even, a_odd} !== {1'b1, 3'd1, 3'd0}) begin
            errors++;
            $display("FAIL chk_set got chk=%b e=%0d o=%0d exp chk=1 e=1 o=0", a_chk, a_even, a_odd);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({a_chk, a_even} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL chk_sticky got chk=%b e=%0d exp chk=1 e=2", a_chk, a_even);
        end
        do_reset();
        tests++;
        if (a_chk !== 1'b0) begin errors++; $display("FAIL chk_clear got %b exp 0", a_chk); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_all_odd();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_window1();
        test_gapped();
`ifdef EVEN_CHECK_EN
        test_chk();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
